// File: rtl/mac_sequencer.sv
// Sequences a shared MAC through a square matrix-vector product y = M*v, one row per result.
// Optional build macro MAC_SEQ_ABORT_EN adds an abort input that cancels a running product.
module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 8,
    parameter int DIM_WIDTH  = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  dim,
    output logic [ADDR_WIDTH-1:0] mat_addr,
    output logic [DIM_WIDTH-1:0]  vec_addr,
    output logic                  mem_rd,
    output logic                  mac_en,
    output logic                  mac_retro,
    input  logic [DATA_WIDTH-1:0] mac_out,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [DIM_WIDTH-1:0]  res_row,
    output logic                  res_valid,
    input  logic                  res_ready,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_r;
    logic [DIM_WIDTH-1:0]  n_r;
    logic [DIM_WIDTH-1:0]  row_r;
    logic [DIM_WIDTH-1:0]  col_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] mat_addr_r;
    logic [DIM_WIDTH-1:0]  vec_addr_r;
    logic                  mem_rd_r;
    logic                  mac_en_r;
    logic                  mac_retro_r;
    logic [DIM_WIDTH-1:0]  res_row_r;
    logic                  res_valid_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic                  abort_pend_r;

    logic                  abort_s;
    logic                  abort_hit_s;
    logic                  dim_ok_s;
    logic                  last_col_s;
    logic                  last_row_s;
    logic [DIM_WIDTH-1:0]  next_col_s;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign abort_hit_s = abort_s && (state_r != S_IDLE);
    assign dim_ok_s    = (dim != {DIM_WIDTH{1'b0}}) && (dim <= DIM_WIDTH'(MAX_DIM));
    assign last_col_s  = (col_r == (n_r - DIM_WIDTH'(1)));
    assign last_row_s  = (row_r == (n_r - DIM_WIDTH'(1)));
    assign next_col_s  = col_r + DIM_WIDTH'(1);

    // Control FSM with all outputs registered; mac_en trails mem_rd to line up with read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            n_r          <= {DIM_WIDTH{1'b0}};
            row_r        <= {DIM_WIDTH{1'b0}};
            col_r        <= {DIM_WIDTH{1'b0}};
            base_r       <= {ADDR_WIDTH{1'b0}};
            mat_addr_r   <= {ADDR_WIDTH{1'b0}};
            vec_addr_r   <= {DIM_WIDTH{1'b0}};
            mem_rd_r     <= 1'b0;
            mac_en_r     <= 1'b0;
            mac_retro_r  <= 1'b0;
            res_row_r    <= {DIM_WIDTH{1'b0}};
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            abort_pend_r <= 1'b0;
        end else begin
            err_r       <= 1'b0;
            done_r      <= 1'b0;
            mac_retro_r <= 1'b0;
            mem_rd_r    <= 1'b0;
            // An abort suppresses the trailing enable so it never overlaps the clear cycle
            mac_en_r    <= mem_rd_r && !abort_hit_s;
            if (abort_hit_s) begin
                state_r      <= S_CLEAR;
                abort_pend_r <= 1'b1;
                mac_retro_r  <= 1'b1;
                res_valid_r  <= 1'b0;
                col_r        <= {DIM_WIDTH{1'b0}};
                busy_r       <= 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start && dim_ok_s) begin
                            n_r         <= dim;
                            row_r       <= {DIM_WIDTH{1'b0}};
                            col_r       <= {DIM_WIDTH{1'b0}};
                            base_r      <= {ADDR_WIDTH{1'b0}};
                            mac_retro_r <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= S_CLEAR;
                        end else if (start) begin
                            err_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        if (abort_pend_r) begin
                            abort_pend_r <= 1'b0;
                            busy_r       <= 1'b0;
                            state_r      <= S_IDLE;
                        end else begin
                            col_r      <= {DIM_WIDTH{1'b0}};
                            mat_addr_r <= base_r;
                            vec_addr_r <= {DIM_WIDTH{1'b0}};
                            mem_rd_r   <= 1'b1;
                            state_r    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (last_col_s) begin
                            col_r   <= {DIM_WIDTH{1'b0}};
                            state_r <= S_WAIT;
                        end else begin
                            col_r      <= next_col_s;
                            mat_addr_r <= base_r + ADDR_WIDTH'(next_col_s);
                            vec_addr_r <= next_col_s;
                            mem_rd_r   <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        res_valid_r <= 1'b1;
                        res_row_r   <= row_r;
                        state_r     <= S_OUT;
                    end
                    S_OUT: begin
                        if (res_ready && last_row_s) begin
                            res_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= S_DONE;
                        end else if (res_ready) begin
                            res_valid_r <= 1'b0;
                            row_r       <= row_r + DIM_WIDTH'(1);
                            base_r      <= base_r + ADDR_WIDTH'(n_r);
                            mac_retro_r <= 1'b1;
                            state_r     <= S_CLEAR;
                        end else begin
                            res_valid_r <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                    default: begin
                        res_valid_r  <= 1'b0;
                        busy_r       <= 1'b0;
                        abort_pend_r <= 1'b0;
                        state_r      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mat_addr  = mat_addr_r;
    assign vec_addr  = vec_addr_r;
    assign mem_rd    = mem_rd_r;
    assign mac_en    = mac_en_r;
    assign mac_retro = mac_retro_r;
    // The MAC holds its sum while in OUT, so the result is taken straight from it while valid
    assign res_data  = res_valid_r ? mac_out : {DATA_WIDTH{1'b0}};
    assign res_row   = res_row_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with behavioural matrix/vector memories and MAC.
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dim;
    logic [5:0] mat_addr;
    logic [3:0] vec_addr;
    logic       mem_rd;
    logic       mac_en;
    logic       mac_retro;
    logic [7:0] mac_out;
    logic [7:0] res_data;
    logic [3:0] res_row;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       done;
    logic       err;
`ifdef MAC_SEQ_ABORT_EN
    logic       abort;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] mat_mem [0:63];
    logic [7:0] vec_mem [0:7];
    logic [7:0] mat_q;
    logic [7:0] vec_q;
    logic [7:0] acc;

    int mem_rd_cnt  = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int valid_cnt   = 0;
    int overlap_cnt = 0;
    int last_mat    = 0;
    int last_vec    = 0;

    mac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dim       (dim),
        .mat_addr  (mat_addr),
        .vec_addr  (vec_addr),
        .mem_rd    (mem_rd),
        .mac_en    (mac_en),
        .mac_retro (mac_retro),
        .mac_out   (mac_out),
        .res_data  (res_data),
        .res_row   (res_row),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef MAC_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) begin
            mat_q <= mat_mem[mat_addr];
            vec_q <= vec_mem[vec_addr[2:0]];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) acc <= 8'd0;
        else if (mac_retro) acc <= 8'd0;
        else if (mac_en) acc <= acc + 8'(mat_q * vec_q);
    end
    assign mac_out = acc;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rd_cnt <= mem_rd_cnt + 1;
            last_mat   <= int'(mat_addr);
            last_vec   <= int'(vec_addr);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (res_valid) valid_cnt <= valid_cnt + 1;
        if (mac_en && mac_retro) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [3:0] d);
        @(negedge clk);
        start = 1'b1;
        dim   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_result(input int r, input int d, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_row"}, 32'(res_row), 32'(r));
        chk({tag, "_data"}, 32'(res_data), 32'(d));
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic load_small();
        for (int i = 0; i < 64; i++) mat_mem[i] = 8'd0;
        for (int i = 0; i < 8; i++) vec_mem[i] = 8'd0;
        mat_mem[0] = 8'd1; mat_mem[1] = 8'd2; mat_mem[2] = 8'd3; mat_mem[3] = 8'd4;
        vec_mem[0] = 8'd5; vec_mem[1] = 8'd6;
    endtask

    task automatic wait_fetch(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_rd) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_fetch"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int rd0;
        int done0;
        int err0;
        int valid0;
        rst       = 1'b1;
        start     = 1'b0;
        dim       = 4'd0;
        res_ready = 1'b1;
`ifdef MAC_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        load_small();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(res_valid), 32'd0);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        chk("reset_retro", 32'(mac_retro), 32'd0);
        rst = 1'b1;

        // dim=2, ready always high, first-result latency
        @(negedge clk);
        start = 1'b1;
        dim   = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk);
            edges++;
        end
        chk("lat_first_valid", 32'(edges), 32'd5);
        chk("d2_r0_row", 32'(res_row), 32'd0);
        chk("d2_r0_data", 32'(res_data), 32'd17);
        chk("d2_busy", 32'(busy), 32'd1);
        wait_result(1, 39, "d2_r1");
        wait_done("d2");

        // backpressure in row 0
        res_ready = 1'b0;
        pulse_start(4'd2);
        wait_result(0, 17, "hold_r0");
        rd0 = mem_rd_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'd17);
            chk("hold_row", 32'(res_row), 32'd0);
        end
        chk("hold_no_rd", 32'(mem_rd_cnt), 32'(rd0));
        res_ready = 1'b1;
        wait_result(1, 39, "hold_r1");
        wait_done("hold");

        // rejected dimensions
        rd0 = mem_rd_cnt;
        pulse_start(4'd0);
        @(negedge clk);
        chk("dim0_err", 32'(err), 32'd1);
        chk("dim0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("dim0_err_pulse", 32'(err), 32'd0);
        pulse_start(4'd9);
        @(negedge clk);
        chk("dim9_err", 32'(err), 32'd1);
        chk("dim9_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("dim9_err_pulse", 32'(err), 32'd0);
        chk("bad_dim_no_rd", 32'(mem_rd_cnt), 32'(rd0));

        // dim=8 all ones, start pulse while busy ignored
        for (int i = 0; i < 64; i++) mat_mem[i] = 8'd1;
        for (int i = 0; i < 8; i++) vec_mem[i] = 8'd1;
        done0 = done_cnt;
        err0  = err_cnt;
        pulse_start(4'd8);
        for (int r = 0; r < 8; r++) begin
            wait_result(r, 8, "d8");
            if (r == 0) begin
                start = 1'b1;
                dim   = 4'd3;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        wait_done("d8");
        chk("d8_last_mat", 32'(last_mat), 32'd63);
        chk("d8_last_vec", 32'(last_vec), 32'd7);
        chk("d8_done_once", 32'(done_cnt), 32'(done0 + 1));
        chk("d8_no_err", 32'(err_cnt), 32'(err0));

        // reset in FETCH of row 1, then a clean rerun
        load_small();
        pulse_start(4'd2);
        wait_result(0, 17, "rst_r0");
        wait_fetch("rst_r1");
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_retro", 32'(mac_retro), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_mat_addr", 32'(mat_addr), 32'd0);
        chk("rst_vec_addr", 32'(vec_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulse_start(4'd2);
        wait_result(0, 17, "rerun_r0");
        wait_result(1, 39, "rerun_r1");
        wait_done("rerun");

`ifdef MAC_SEQ_ABORT_EN
        // abort during FETCH of row 0
        done0  = done_cnt;
        valid0 = valid_cnt;
        pulse_start(4'd2);
        wait_fetch("abort");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_retro", 32'(mac_retro), 32'd1);
        chk("abort_en", 32'(mac_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_retro_once", 32'(mac_retro), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_valid", 32'(valid_cnt), 32'(valid0));
        chk("abort_no_done", 32'(done_cnt), 32'(done0));
        pulse_start(4'd2);
        wait_result(0, 17, "post_abort_r0");
        wait_result(1, 39, "post_abort_r1");
        wait_done("post_abort");
`endif

        chk("retro_en_overlap", 32'(overlap_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
